// File: rtl/async_counter_up_pkg.sv
// rtl/async_counter_up_pkg.sv - shared default width for the ripple up-counter
package async_counter_up_pkg;
  localparam int COUNTER_WIDTH = 4;
endpackage

// File: rtl/async_counter_up_t_ff.sv
// rtl/async_counter_up_t_ff.sv - toggle flip-flop with asynchronous active-low clear
module t_ff (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= 1'b0;
    end else if (t) begin
      r_q <= ~r_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/async_counter_up.sv
// rtl/async_counter_up.sv - ripple binary up-counter built from a chain of toggle flops
module async_counter_up
  import async_counter_up_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d,
  output logic [WIDTH-1:0] cq
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_stage_clk;
  logic [WIDTH-1:0] w_stage_t;

  // Each higher stage toggles when the stage below falls 1->0, seen as a rising edge of its inverse.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign w_stage_clk[i] = clk;
      assign w_stage_t[i]   = d;
    end else begin : g_ripple
      assign w_stage_clk[i] = ~w_q[i-1];
      assign w_stage_t[i]   = 1'b1;
    end

    t_ff u_t_ff (
      .clk   (w_stage_clk[i]),
      .reset (reset),
      .t     (w_stage_t[i]),
      .q     (w_q[i])
    );
  end

  assign cq = w_q;

endmodule

// File: tb/tb_async_counter_up.sv
// tb/tb_async_counter_up.sv - self-checking bench for the ripple up-counter
module tb_async_counter_up;
  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         reset;
  logic         d;
  logic [W-1:0] cq;

  int n_checks;
  int n_pass;
  int model;

  async_counter_up #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .cq    (cq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model    = 0;
    reset    = 1'b0;
    d        = 1'b1;

    #1 check("reset_initial", int'(cq), 0);
    @(posedge clk) #1 check("reset_edge5", int'(cq), 0);
    #4;
    reset = 1'b1;
    d     = 1'b0;
    @(posedge clk) #1 check("hold_d0", int'(cq), 0);
    #4 d = 1'b1;
    model = 0;
    repeat (10) begin
      @(posedge clk) #1;
      model = (model + 1) % MOD;
      check("count_up", int'(cq), model);
    end
    check("count_ten", int'(cq), 10);

    #4 reset = 1'b0;
    #1 check("async_clear", int'(cq), 0);
    @(posedge clk) #1 check("clear_hold125", int'(cq), 0);
    @(posedge clk) #1 check("clear_hold135", int'(cq), 0);
    #4;
    reset = 1'b1;
    d     = 1'b1;
    model = 0;
    repeat (6) begin
      @(posedge clk) #1;
      model = (model + 1) % MOD;
      check("restart_count", int'(cq), model);
    end
    check("restart_six", int'(cq), 6);

    #1 reset = 1'b0;
    #1 check("wrap_pre_clear", int'(cq), 0);
    reset = 1'b1;
    model = 0;
    for (int i = 1; i <= MOD; i++) begin
      @(posedge clk) #1;
      model = (model + 1) % MOD;
      check("wrap_seq", int'(cq), model);
      if (i == 8) check("seven_to_eight", int'(cq), 8);
    end
    check("wrap_zero", int'(cq), 0);

    // Random enable pattern with occasional mid-cycle clear pulses.
    repeat (300) begin
      @(negedge clk);
      d = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        #1 reset = 1'b0;
        #1 check("rand_clear", int'(cq), 0);
        model = 0;
        #1 reset = 1'b1;
      end
      @(posedge clk) #1;
      if (d) model = (model + 1) % MOD;
      check("rand_count", int'(cq), model);
      #1 d = ~d;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
